mem_wb_writeback: RTL

//   MEM/WB pipeline register and write-back select feeding the register file write port
//   (WriteRegister/WriteData/RegWrite). Captures memory-stage results each clock and

---
 rtl/mem_wb_writeback.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mem_wb_writeback.sv
// mem_wb_writeback: MEM/WB pipeline register with write-back source select.
//   Captures the memory-stage result each clock (flush > stall > load) and
//   drives the register-file write port. Link (jal) instructions are redirected
//   to LINK_REG with PC+8 as data. Writes to register 0 are never enabled.
//   A free-running retired-instruction counter is kept for debug.
// Ports:
//   Clk, Reset          clock, asynchronous active-high reset
//   Stall, Flush        hold WB contents / replace incoming instruction by bubble
//   Valid_in .. PCPlus4_in   memory-stage instruction fields
//   Valid_out           WB stage holds a real instruction
//   RegWrite            register-file write enable
//   WriteRegister       register-file write address
//   WriteData           register-file write data
//   RetireCount         instructions retired since reset
module mem_wb_writeback #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned LINK_REG   = 31,
   parameter int unsigned CNT_WIDTH  = 32
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  Stall,
   input  logic                  Flush,
   input  logic                  Valid_in,
   input  logic                  RegWrite_in,
   input  logic                  MemToReg_in,
   input  logic                  Link_in,
   input  logic [ADDR_WIDTH-1:0] WriteRegister_in,
   input  logic [DATA_WIDTH-1:0] ALUResult_in,
   input  logic [DATA_WIDTH-1:0] MemReadData_in,
   input  logic [DATA_WIDTH-1:0] PCPlus4_in,
   output logic                  Valid_out,
   output logic                  RegWrite,
   output logic [ADDR_WIDTH-1:0] WriteRegister,
   output logic [DATA_WIDTH-1:0] WriteData,
   output logic [CNT_WIDTH-1:0]  RetireCount
);

   localparam logic [ADDR_WIDTH-1:0] LINK_DEST = ADDR_WIDTH'(LINK_REG);

   logic                  valid_q,     valid_d;
   logic                  regwrite_q,  regwrite_d;
   logic                  memtoreg_q,  memtoreg_d;
   logic                  link_q,      link_d;
   logic [ADDR_WIDTH-1:0] dest_q,      dest_d;
   logic [DATA_WIDTH-1:0] alu_q,       alu_d;
   logic [DATA_WIDTH-1:0] mem_q,       mem_d;
   logic [DATA_WIDTH-1:0] linkdata_q,  linkdata_d;
   logic [CNT_WIDTH-1:0]  retire_cnt_q, retire_cnt_d;

   // Next-state: flush > stall > load; an invalid incoming slot is stored as a bubble.
   always_comb begin
      valid_d      = valid_q;
      regwrite_d   = regwrite_q;
      memtoreg_d   = memtoreg_q;
      link_d       = link_q;
      dest_d       = dest_q;
      alu_d        = alu_q;
      mem_d        = mem_q;
      linkdata_d   = linkdata_q;
      retire_cnt_d = retire_cnt_q;

      // The instruction leaving WB retires even when the incoming one is flushed.
      if (valid_q && !Stall) begin
         retire_cnt_d = retire_cnt_q + CNT_WIDTH'(1);
      end

      if (Flush || (!Stall && !Valid_in)) begin
         valid_d    = 1'b0;
         regwrite_d = 1'b0;
         memtoreg_d = 1'b0;
         link_d     = 1'b0;
         dest_d     = '0;
         alu_d      = '0;
         mem_d      = '0;
         linkdata_d = '0;
      end else if (!Stall) begin
         valid_d    = 1'b1;
         regwrite_d = RegWrite_in;
         link_d     = Link_in;
         alu_d      = ALUResult_in;
         mem_d      = MemReadData_in;
         // jal overrides destination and source select; its data is PC+8.
         memtoreg_d = Link_in ? 1'b0 : MemToReg_in;
         dest_d     = Link_in ? LINK_DEST : WriteRegister_in;
         linkdata_d = PCPlus4_in + DATA_WIDTH'(4);
      end
   end

   // State register.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         valid_q      <= 1'b0;
         regwrite_q   <= 1'b0;
         memtoreg_q   <= 1'b0;
         link_q       <= 1'b0;
         dest_q       <= '0;
         alu_q        <= '0;
         mem_q        <= '0;
         linkdata_q   <= '0;
         retire_cnt_q <= '0;
      end else begin
         valid_q      <= valid_d;
         regwrite_q   <= regwrite_d;
         memtoreg_q   <= memtoreg_d;
         link_q       <= link_d;
         dest_q       <= dest_d;
         alu_q        <= alu_d;
         mem_q        <= mem_d;
         linkdata_q   <= linkdata_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   // Write-port decode from stored fields; register 0 is never written.
   always_comb begin
      WriteData = '0;
      if (valid_q) begin
         if (link_q) begin
            WriteData = linkdata_q;
         end else if (memtoreg_q) begin
            WriteData = mem_q;
         end else begin
            WriteData = alu_q;
         end
      end
   end

   assign RegWrite      = valid_q & regwrite_q & (dest_q != '0);
   assign Valid_out     = valid_q;
   assign WriteRegister = dest_q;
   assign RetireCount   = retire_cnt_q;

endmodule
